branch_predictor_bht: RTL and testbench

BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

---
 rtl/branch_predictor_bht.sv | 227 ++++++++++++++++++++++
 tb/tb_branch_predictor_bht.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
//
// Direct-mapped branch history table with per-entry saturating counters and
// branch targets. Lookups are combinational from the registered table; updates
// from execute land on the following clock edge. After reset or a flush the
// table is cleared one entry per cycle (INIT); during that time busy_o is high,
// lookups miss and updates are dropped. Update/misprediction statistics are
// kept in saturating counters that survive a flush.
//
// Ports
//   clk_i            clock, rising edge
//   reset_i          synchronous reset, active low
//   desactivar_bp_i  1 = predictions suppressed (training still happens)
//   flush_i          invalidate whole table
//   pc_f_i           fetch PC for lookup
//   pred_taken_o     predicted taken
//   pred_hit_o       valid entry with matching tag
//   pred_target_o    predicted target (0 on miss)
//   prediccion_o     counter of looked-up entry (0 on miss)
//   upd_we_i         resolved-branch update strobe
//   upd_pc_i         PC of resolved branch
//   upd_taken_i      actual outcome
//   upd_target_i     actual target
//   upd_pred_taken_i prediction that was made for this branch
//   busy_o           table initialising
//   upd_cnt_o        counted updates
//   mispred_cnt_o    counted mispredictions
// -----------------------------------------------------------------------------
module branch_predictor_bht #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             desactivar_bp_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  pc_f_i,
  output logic             pred_taken_o,
  output logic             pred_hit_o,
  output logic [XLEN-1:0]  pred_target_o,
  output logic [CTR_W-1:0] prediccion_o,
  input  logic             upd_we_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] upd_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             init_clr;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];

  logic [CNT_W-1:0] upd_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  // Byte-offset bits of both PCs carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f_i[1:0], upd_pc_i[1:0]};

  // ---------------------------------------------------------------------------
  // Init / ready control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= ST_INIT;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    init_clr  = 1'b0;
    busy_o    = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy_o   = 1'b1;
        init_clr = 1'b1;
        if (flush_i) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == IDX_LAST) begin
          state_d   = ST_READY;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      ST_READY: begin
        if (flush_i) begin
          state_d   = ST_INIT;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = ST_INIT;
        clr_idx_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lookup (zero latency, from registered table)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = pc_f_i[IDX_W+1:2];
  assign f_tag = pc_f_i[XLEN-1:IDX_W+2];

  always_comb begin
    f_hit = (state_q == ST_READY) && !desactivar_bp_i &&
            valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_hit_o    = f_hit;
    pred_taken_o  = f_hit && ctr_q[f_idx][CTR_W-1];
    pred_target_o = f_hit ? tgt_q[f_idx] : '0;
    prediccion_o  = f_hit ? ctr_q[f_idx] : '0;
  end

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_active;
  logic             ent_we;
  logic [CTR_W-1:0] ctr_d;

  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[XLEN-1:IDX_W+2];

  // A flush in the same cycle wins over the table write: the entry would be
  // wiped by the following INIT pass anyway.
  assign u_active = (state_q == ST_READY) && !flush_i && upd_we_i;

  always_comb begin
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    ent_we = 1'b0;
    ctr_d  = ctr_q[u_idx];
    if (u_active) begin
      if (u_hit) begin
        ent_we = 1'b1;
        if (upd_taken_i) begin
          ctr_d = (ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + CTR_W'(1);
        end else begin
          ctr_d = (ctr_q[u_idx] == '0) ? '0 : ctr_q[u_idx] - CTR_W'(1);
        end
      end else if (upd_taken_i) begin
        // Miss and taken: allocate, evicting whatever aliased here.
        ent_we = 1'b1;
        ctr_d  = CTR_WEAK;
      end
    end
  end

  // Table storage. Only valid and counters need clearing; tag/target are
  // qualified by valid. Reset suppresses every table write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      if (init_clr) begin
        valid_q[clr_idx_q] <= 1'b0;
        ctr_q[clr_idx_q]   <= '0;
      end else if (ent_we) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        ctr_q[u_idx]   <= ctr_d;
        if (upd_taken_i) begin
          tgt_q[u_idx] <= upd_target_i;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics (not touched by flush)
  // ---------------------------------------------------------------------------
  logic stat_en;
  assign stat_en = (state_q == ST_READY) && upd_we_i && !desactivar_bp_i;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      upd_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else if (stat_en) begin
      if (upd_cnt_q != '1) begin
        upd_cnt_q <= upd_cnt_q + CNT_W'(1);
      end
      if ((upd_pred_taken_i != upd_taken_i) && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  assign upd_cnt_o     = upd_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// Testbench for branch_predictor_bht (XLEN=32, ENTRIES=16, CTR_W=2, CNT_W=32).
// Stimulus is driven 1 ns after each rising edge; the expected outputs for that
// cycle are pushed into a queue from a reference model, and a monitor on the
// falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        desactivar_bp_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] pc_f_i = '0;
  logic        pred_taken_o, pred_hit_o;
  logic [31:0] pred_target_o;
  logic [1:0]  prediccion_o;
  logic        upd_we_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_pred_taken_i = 1'b0;
  logic        busy_o;
  logic [31:0] upd_cnt_o, mispred_cnt_o;

  always #5 clk = ~clk;

  branch_predictor_bht #(.XLEN(32), .ENTRIES(16), .CTR_W(2), .CNT_W(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .desactivar_bp_i(desactivar_bp_i),
    .flush_i(flush_i), .pc_f_i(pc_f_i), .pred_taken_o(pred_taken_o),
    .pred_hit_o(pred_hit_o), .pred_target_o(pred_target_o),
    .prediccion_o(prediccion_o), .upd_we_i(upd_we_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_pred_taken_i(upd_pred_taken_i), .busy_o(busy_o),
    .upd_cnt_o(upd_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] pred;
    logic        busy;
    logic [31:0] upd;
    logic [31:0] mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // ---------------- reference model ----------------
  bit          m_known = 0;
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int          m_init_left;
  longint      m_upd, m_mis;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic exp_t predict(logic dis, logic [31:0] pc);
    exp_t e;
    int   i = idx_of(pc);
    bit   h = (m_init_left == 0) && !dis && m_valid[i] && (m_tag[i] == tag_of(pc));
    e.hit   = h;
    e.taken = h && (m_ctr[i] >= 2);
    e.tgt   = h ? m_tgt[i] : 32'd0;
    e.pred  = h ? 32'(m_ctr[i]) : 32'd0;
    e.busy  = (m_init_left != 0);
    e.upd   = 32'(m_upd);
    e.mis   = 32'(m_mis);
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_init_left = N;
  endtask

  task automatic model_edge(logic rst, logic fl, logic dis, logic we,
                            logic [31:0] upc, logic t, logic [31:0] utgt, logic pt);
    int i;
    if (!rst) begin
      model_clear();
      m_upd   = 0;
      m_mis   = 0;
      m_known = 1;
    end else if (m_init_left != 0) begin
      if (fl) m_init_left = N;
      else    m_init_left--;
    end else begin
      if (we && !dis) begin
        if (m_upd < 64'hFFFF_FFFF) m_upd++;
        if (pt != t && m_mis < 64'hFFFF_FFFF) m_mis++;
      end
      if (fl) begin
        model_clear();
      end else if (we) begin
        i = idx_of(upc);
        if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
          if (t) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = utgt;
          end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end
        end else if (t) begin
          m_valid[i] = 1;
          m_tag[i]   = tag_of(upc);
          m_tgt[i]   = utgt;
          m_ctr[i]   = 2;
        end
      end
    end
  endtask

  // Drive one cycle of inputs (called 1 ns after a rising edge), queue the
  // expected outputs, then advance the model across the next edge.
  task automatic apply(logic rst, logic fl, logic dis, logic [31:0] fpc,
                       logic we, logic [31:0] upc, logic t, logic [31:0] utgt, logic pt);
    reset_i = rst; flush_i = fl; desactivar_bp_i = dis; pc_f_i = fpc;
    upd_we_i = we; upd_pc_i = upc; upd_taken_i = t; upd_target_i = utgt;
    upd_pred_taken_i = pt;
    if (m_known) exp_q.push_back(predict(dis, fpc));
    @(posedge clk);
    #1;
    model_edge(rst, fl, dis, we, upc, t, utgt, pt);
  endtask

  task automatic look(logic [31:0] fpc, logic dis);
    apply(1, 0, dis, fpc, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic upd(logic [31:0] upc, logic t, logic [31:0] utgt, logic pt,
                     logic [31:0] fpc, logic dis);
    apply(1, 0, dis, fpc, 1, upc, t, utgt, pt);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pred_hit",    {31'd0, pred_hit_o},   {31'd0, e.hit});
      chk("pred_taken",  {31'd0, pred_taken_o}, {31'd0, e.taken});
      chk("pred_target", pred_target_o,         e.tgt);
      chk("prediccion",  {30'd0, prediccion_o}, e.pred);
      chk("busy",        {31'd0, busy_o},       {31'd0, e.busy});
      chk("upd_cnt",     upd_cnt_o,             e.upd);
      chk("mispred_cnt", mispred_cnt_o,         e.mis);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    apply(0, 0, 0, 32'h40, 0, 32'h0, 0, 32'h0, 0);
    apply(0, 1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0);  // reset dominates
    // INIT window: busy for 16 cycles, lookups of 0x40 miss
    repeat (N) look(32'h40, 0);
    look(32'h40, 0);

    // Training of 0x40 and same-cycle read-old behaviour
    upd(32'h40, 1, 32'h100, 0, 32'h40, 0);
    look(32'h40, 0);
    upd(32'h40, 1, 32'h100, 1, 32'h40, 0);
    upd(32'h40, 1, 32'h100, 1, 32'h40, 0);
    look(32'h40, 0);
    upd(32'h40, 0, 32'h0, 1, 32'h40, 0);
    upd(32'h40, 0, 32'h0, 1, 32'h40, 0);
    look(32'h40, 0);

    // Alias at index 0
    look(32'h80, 0);
    upd(32'h80, 1, 32'h200, 0, 32'h80, 0);
    look(32'h80, 0);
    look(32'h40, 0);

    // Disabled predictor still trains, statistics frozen
    upd(32'h40, 1, 32'h140, 1, 32'h40, 0);
    look(32'h40, 1);
    upd(32'h40, 0, 32'h0, 1, 32'h40, 1);
    look(32'h40, 0);

    // Flush: statistics retained, table empty after INIT
    apply(1, 1, 0, 32'h40, 0, 32'h0, 0, 32'h0, 0);
    repeat (N + 2) look(32'h40, 0);
    look(32'h80, 0);

    // Randomised traffic over a small PC pool so aliasing and hits are common
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] fpc, upc;
      logic        rst, fl, dis, we;
      fpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      rst = ($urandom_range(0, 299) != 0);
      fl  = ($urandom_range(0, 79) == 0);
      dis = ($urandom_range(0, 7) == 0);
      we  = ($urandom_range(0, 1) == 1);
      apply(rst, fl, dis, fpc, we, upc, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)));
    end

    look(32'h0, 0);
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
